capture_pix_writer: RTL and testbench
=====================================

// Module: capture_pix_writer
// PURPOSE
//  Write-side controller for the per-pixel capture snapshot RAM. Accepts the pixel/photon word stream,
//  waits for software arm and a trigger, then writes a bounded run of words into port A of the capture
//  BRAM block (we/en/addr/wr_data). Software reads the results through BRAM port B after done.
// PARAMETERS
//  ADDR_W   10   BRAM address width; depth = 2**ADDR_W words
//  DATA_W   32   data word width; matches BRAM port A
// PORTS
//  clk           in   1         fabric clock; also drives BRAM port A
//  rst           in   1         asynchronous, active-high reset
//  in_valid      in   1         input word valid (no backpressure)
//  in_data       in   DATA_W    input pixel word
//  arm           in   1         software arm level; rising edge acts
//  trig          in   1         capture trigger pulse/level; sampled only in ARMED
//  capture_len   in   ADDR_W+1  words to capture; 0 or >2**ADDR_W means 2**ADDR_W
//  bram_we       out  1         BRAM port A write enable
//  bram_en_a     out  1         BRAM port A enable (== bram_we)
//  bram_addr     out  ADDR_W    BRAM port A address
//  bram_wr_data  out  DATA_W    BRAM port A write data
//  busy          out  1         high in ARMED or CAPTURE
//  done          out  1         high in DONE; held until next arm edge
//  wr_count      out  ADDR_W+1  words written since trigger, saturating at capture length
//  trig_addr     out  ADDR_W    address holding the trigger word (0 without macro)
// BEHAVIOUR
//  - Async reset: state=IDLE; all outputs 0; arm edge register 0. BRAM contents untouched.
//  - arm_edge = arm & ~arm_q (arm_q is a registered copy).
//  - FSM: IDLE -arm_edge-> ARMED; ARMED -trig-> CAPTURE; CAPTURE -last word written-> DONE;
//    DONE -arm_edge-> ARMED.
//  - Entering ARMED clears addr ptr, wr_count, trig_addr and done.
//  - arm_edge in ARMED re-arms (same clear). arm_edge in CAPTURE is ignored.
//  - trig outside ARMED is ignored. Simultaneous arm_edge and trig in IDLE/DONE: arm only.
//  - Write on trigger cycle: the cycle where trig=1 in ARMED counts as a capture cycle. If in_valid
//    is also 1 in that cycle, that word is the first word captured.
//  - Each accepted word (CAPTURE state, or trigger cycle, with in_valid=1):
//    - bram_we=bram_en_a=1 exactly one cycle later.
//    - bram_addr = ptr, bram_wr_data = in_data.
//    - ptr increments mod 2**ADDR_W; wr_count increments.
//  - Fixed latency: 1 cycle from in_valid to bram_we. All port-A outputs registered.
//  - Gaps in in_valid stall the capture; there is no timeout.
//  - Completion: when wr_count reaches L (effective capture_len), FSM -> DONE on the same edge as
//    the final write. done=1 one cycle after that write. No writes occur in DONE/IDLE.
//  - capture_len is sampled at the trigger cycle. Changes afterwards have no effect until the next
//    trigger.
//  - L=2**ADDR_W fills the RAM exactly; ptr wraps to 0 and is not reused.
//  - Reset mid-capture aborts immediately; a partial buffer remains in RAM; done stays 0.
// CONFIGURATION
//  CAPTURE_PRETRIG_EN defined:
//    - In ARMED, every valid word is written circularly (ptr wraps freely, wr_count stays 0).
//    - On trig, trig_addr latches the ptr used for the trigger-cycle word (or the next ptr if
//      in_valid=0).
//    - L post-trigger words are then written, including the trigger word. Pre-trigger history is the
//      remaining 2**ADDR_W-L words, oldest at trig_addr+L mod depth.
//  Not defined: ARMED writes nothing; trig_addr is constant 0; capture starts at address 0.
// TESTING
//  1 arm edge, trig, capture_len=4, in_valid continuous D0..D3 -> writes addr 0..3 = D0..D3;
//    done=1 one cycle after the last write; wr_count=4.
//  2 capture_len=0, continuous valid -> 1024 writes, addr 0..1023, then done; no 1025th write.
//  3 in_valid toggling 1,0,1,0 with capture_len=3 -> addresses 0,1,2 only on valid words;
//    bram_we never high for gap cycles.
//  4 trig before arm; arm+trig same cycle -> no writes, busy=1 (ARMED); later trig starts capture.
//  5 rst asserted after 5 of 8 words -> outputs 0 same cycle, IDLE; re-arm restarts at addr 0.
//  6 CAPTURE_PRETRIG_EN, ARMED with 1030 valid words, trig, capture_len=16 -> trig_addr=6;
//    16 writes at addr 6..21; done.

Source files
------------

// File: rtl/capture_pix_writer.sv
// Write-side controller for the capture snapshot BRAM: arm, trigger, then a bounded run of port-A writes.
// Optional pre-trigger circular history is enabled by defining CAPTURE_PRETRIG_EN.
module capture_pix_writer #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              arm,
    input  logic              trig,
    input  logic [ADDR_W:0]   capture_len,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1) << ADDR_W;
`ifdef CAPTURE_PRETRIG_EN
    localparam bit PRETRIG = 1'b1;
`else
    localparam bit PRETRIG = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state;
    logic              arm_q;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  len_q;

    logic              arm_edge;
    logic              do_arm;
    logic              trig_cycle;
    logic              accept;
    logic              pre_wr;
    logic              last;
    logic [LEN_W-1:0]  len_in_eff;
    logic [LEN_W-1:0]  len_cur;

    // Decode of the current cycle: arm edge wins over trigger, capture_len only matters at trigger
    always_comb begin
        arm_edge   = arm & ~arm_q;
        do_arm     = arm_edge && (state != CAPTURE);
        trig_cycle = (state == ARMED) && !arm_edge && trig;
        len_in_eff = ((capture_len == '0) || (capture_len > DEPTH)) ? DEPTH : capture_len;
        len_cur    = trig_cycle ? len_in_eff : len_q;
        accept     = in_valid && (trig_cycle || (state == CAPTURE));
        pre_wr     = PRETRIG && in_valid && (state == ARMED) && !arm_edge && !trig;
        last       = accept && ((wr_count + LEN_W'(1)) == len_cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            arm_q        <= 1'b0;
            ptr          <= '0;
            len_q        <= '0;
            bram_we      <= 1'b0;
            bram_en_a    <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_count     <= '0;
            trig_addr    <= '0;
        end else begin
            arm_q     <= arm;
            bram_we   <= 1'b0;
            bram_en_a <= 1'b0;

            if (accept || pre_wr) begin
                bram_we      <= 1'b1;
                bram_en_a    <= 1'b1;
                bram_addr    <= ptr;
                bram_wr_data <= in_data;
                ptr          <= ptr + ADDR_W'(1);
            end
            if (accept) begin
                wr_count <= wr_count + LEN_W'(1);
            end

            case (state)
                IDLE: ;
                ARMED: begin
                    if (trig_cycle) begin
                        len_q <= len_in_eff;
                        if (PRETRIG) begin
                            trig_addr <= ptr;
                        end
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: done <= 1'b1;
                default: state <= IDLE;
            endcase

            // Arming (from IDLE, ARMED or DONE) restarts the buffer from a clean slate
            if (do_arm) begin
                state     <= ARMED;
                busy      <= 1'b1;
                done      <= 1'b0;
                ptr       <= '0;
                wr_count  <= '0;
                trig_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_capture_pix_writer.sv
// Directed self-checking bench for capture_pix_writer; port-A writes are logged by a negedge monitor.
module tb_capture_pix_writer;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              arm;
    logic              trig;
    logic [ADDR_W:0]   capture_len;
    logic              bram_we;
    logic              bram_en_a;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic [ADDR_W-1:0] trig_addr;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    int                en_bad = 0;

    capture_pix_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .arm(arm), .trig(trig), .capture_len(capture_len),
        .bram_we(bram_we), .bram_en_a(bram_en_a), .bram_addr(bram_addr),
        .bram_wr_data(bram_wr_data), .busy(busy), .done(done),
        .wr_count(wr_count), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            wa_q.push_back(bram_addr);
            wd_q.push_back(bram_wr_data);
        end
    end

    always @(negedge clk) begin
        if (bram_we !== bram_en_a) en_bad++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [DATA_W-1:0] d, input logic t);
        in_valid = v;
        in_data  = d;
        trig     = t;
        step();
        trig     = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic chk_writes(input string tag, input int base, input int n,
                              input int addr0, input logic [DATA_W-1:0] data0);
        int errs = 0;
        chk({tag, "_count"}, 64'(wa_q.size() - base), 64'(n));
        if (wa_q.size() - base == n) begin
            for (int i = 0; i < n; i++) begin
                if (wa_q[base+i] !== ADDR_W'(addr0 + i)) errs++;
                if (wd_q[base+i] !== data0 + DATA_W'(i)) errs++;
            end
        end
        chk({tag, "_seq"}, 64'(errs), 64'(0));
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; arm = 1'b0; trig = 1'b0; capture_len = '0;
        step();
        chk("rst_outputs", 64'({bram_we, bram_en_a, busy, done}), 64'(0));
        chk("rst_addr", 64'(bram_addr), 64'(0));
        chk("rst_count", 64'(wr_count), 64'(0));
        rst = 1'b0;
        step();

        // trigger while idle is ignored
        send(1'b1, 32'hDEAD_0000, 1'b1);
        step();
        chk("idle_trig_busy", 64'(busy), 64'(0));
        chk("idle_trig_writes", 64'(wa_q.size()), 64'(0));

        // 1: basic run of 4
        base = wa_q.size();
        capture_len = 11'd4;
        do_arm();
        chk("t1_busy_armed", 64'(busy), 64'(1));
        send(1'b1, 32'h0000_00D0, 1'b1);
        chk("t1_first_we", 64'({bram_we, bram_addr}), 64'({1'b1, 10'd0}));
        chk("t1_first_data", 64'(bram_wr_data), 64'h0000_00D0);
        capture_len = 11'd100;
        send(1'b1, 32'h0000_00D1, 1'b0);
        send(1'b1, 32'h0000_00D2, 1'b0);
        send(1'b1, 32'h0000_00D3, 1'b0);
        chk("t1_last_we", 64'({bram_we, bram_addr}), 64'({1'b1, 10'd3}));
        chk("t1_done_not_yet", 64'(done), 64'(0));
        send(1'b1, 32'h0000_00D4, 1'b0);
        chk("t1_done", 64'({done, busy, bram_we}), 64'({1'b1, 1'b0, 1'b0}));
        chk("t1_wr_count", 64'(wr_count), 64'(4));
        send(1'b1, 32'h0000_00D5, 1'b0);
        step();
        chk_writes("t1", base, 4, 0, 32'h0000_00D0);

        // 2: capture_len 0 fills the whole RAM exactly
        base = wa_q.size();
        capture_len = 11'd0;
        do_arm();
        chk("t2_done_cleared", 64'(done), 64'(0));
        send(1'b1, 32'hA000_0000, 1'b1);
        for (int i = 1; i < 1024; i++) send(1'b1, 32'hA000_0000 + DATA_W'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 32'hBBBB_0000, 1'b0);
        chk("t2_done", 64'(done), 64'(1));
        chk("t2_wr_count", 64'(wr_count), 64'(1024));
        chk_writes("t2", base, 1024, 0, 32'hA000_0000);

        // 3: gapped input, capture_len 3
        base = wa_q.size();
        capture_len = 11'd3;
        do_arm();
        send(1'b1, 32'h0000_0030, 1'b1);
        send(1'b0, 32'h0000_0EEE, 1'b0);
        chk("t3_gap_we", 64'(bram_we), 64'(0));
        send(1'b1, 32'h0000_0031, 1'b0);
        send(1'b0, 32'h0000_0EEE, 1'b0);
        chk("t3_gap2_we", 64'(bram_we), 64'(0));
        chk("t3_busy_mid", 64'(busy), 64'(1));
        send(1'b1, 32'h0000_0032, 1'b0);
        send(1'b0, 32'h0000_0EEE, 1'b0);
        send(1'b0, 32'h0000_0EEE, 1'b0);
        chk("t3_done", 64'(done), 64'(1));
        chk_writes("t3", base, 3, 0, 32'h0000_0030);

        // 4: trig in DONE ignored; arm+trig together only arms
        base = wa_q.size();
        send(1'b1, 32'h0000_0444, 1'b1);
        step();
        chk("t4_done_trig", 64'({done, busy}), 64'({1'b1, 1'b0}));
        capture_len = 11'd2;
        arm = 1'b1;
        send(1'b1, 32'h0000_0445, 1'b1);
        chk("t4_arm_trig", 64'({busy, done, bram_we}), 64'({1'b1, 1'b0, 1'b0}));
        for (int i = 0; i < 3; i++) send(1'b1, 32'h0000_0446, 1'b0);
        chk("t4_armed_nowrite", 64'(wa_q.size() - base), 64'(0));
        send(1'b1, 32'h0000_0040, 1'b1);
        send(1'b1, 32'h0000_0041, 1'b0);
        send(1'b1, 32'h0000_0042, 1'b0);
        step();
        arm = 1'b0;
        chk("t4_done", 64'(done), 64'(1));
        chk_writes("t4", base, 2, 0, 32'h0000_0040);
        step();

        // 5: reset after 5 of 8 words aborts; re-arm restarts at 0
        base = wa_q.size();
        capture_len = 11'd8;
        do_arm();
        send(1'b1, 32'h0000_0050, 1'b1);
        for (int i = 1; i < 5; i++) send(1'b1, 32'h0000_0050 + DATA_W'(i), 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_out", 64'({bram_we, bram_en_a, busy, done}), 64'(0));
        chk("t5_rst_count", 64'(wr_count), 64'(0));
        chk_writes("t5a", base, 5, 0, 32'h0000_0050);
        step();
        rst = 1'b0;
        step();
        chk("t5_idle", 64'({busy, done}), 64'(0));
        base = wa_q.size();
        capture_len = 11'd2;
        do_arm();
        send(1'b1, 32'h0000_0060, 1'b1);
        send(1'b1, 32'h0000_0061, 1'b0);
        step();
        chk("t5_redone", 64'(done), 64'(1));
        chk_writes("t5b", base, 2, 0, 32'h0000_0060);

`ifdef CAPTURE_PRETRIG_EN
        // 6: pre-trigger history then 16 post-trigger words from trig_addr
        capture_len = 11'd16;
        do_arm();
        for (int i = 0; i < 1030; i++) send(1'b1, 32'hC000_0000 + DATA_W'(i), 1'b0);
        chk("t6_pre_count", 64'(wr_count), 64'(0));
        send(1'b0, 32'h0, 1'b1);
        chk("t6_trig_addr", 64'(trig_addr), 64'(6));
        base = wa_q.size();
        for (int i = 0; i < 16; i++) send(1'b1, 32'hD000_0000 + DATA_W'(i), 1'b0);
        step();
        chk("t6_done", 64'(done), 64'(1));
        chk_writes("t6", base, 16, 6, 32'hD000_0000);
`else
        chk("t6_trig_addr_zero", 64'(trig_addr), 64'(0));
`endif

        chk("en_equals_we", 64'(en_bad), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
